uart_cmd_responder: RTL



---
 rtl/uart_cmd_pkg.sv | 11 +
 rtl/uart_cmd_responder_if.sv | 11 +
 rtl/uart_cmd_decode.sv | 16 +
 rtl/uart_cmd_responder.sv | 110 +++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: states, command codes, ASCII constants and response ROM
package uart_cmd_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ECHO, S_EVAL, S_RESP} state_t;
  localparam logic [1:0] CMD_RUN = 2'd0, CMD_CLEAR = 2'd1, CMD_MODE = 2'd2, CMD_UP = 2'd3;
  localparam logic [7:0] ASCII_CR = 8'h0D, ASCII_LF = 8'h0A;
  localparam logic [3:0][7:0] RESP_OK = {ASCII_LF, ASCII_CR, 8'h4B, 8'h4F};
  localparam logic [3:0][7:0] RESP_ER = {ASCII_LF, ASCII_CR, 8'h52, 8'h45};
  function automatic logic [7:0] resp_byte(input logic err, input logic [1:0] idx);
    return err ? RESP_ER[idx] : RESP_OK[idx];
  endfunction
endpackage

// File: rtl/uart_cmd_responder_if.sv
// uart_cmd_responder_if: RX/TX FIFO handshake between responder (master) and uart_controller (slave)
interface uart_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_push_data;
  modport master (input rx_data, rx_empty, tx_full, output rx_pop, tx_push, tx_push_data);
  modport slave (output rx_data, rx_empty, tx_full, input rx_pop, tx_push, tx_push_data);
endinterface

// File: rtl/uart_cmd_decode.sv
// uart_cmd_decode: case-insensitive command letter to {valid, code}
module uart_cmd_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid,
  output logic [1:0] code
);
  logic [7:0] up;
  // clearing bit 5 folds only the lowercase letter onto its uppercase form
  always_comb begin
    up = ch & 8'hDF;
    valid = up == "R" || up == "C" || up == "M" || up == "U";
    code = up == "C" ? CMD_CLEAR : up == "M" ? CMD_MODE : up == "U" ? CMD_UP : CMD_RUN;
  end
endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: CR-terminated command lines to strobes plus OK/ER reply; UART_CMD_ECHO_EN echoes every byte
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int LINE_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_responder_if.master fifo,
  output logic                 o_cmd_valid,
  output logic [1:0]           o_cmd_code,
  output logic                 o_busy
);
  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LINE_MAX);
  state_t state_q, state_d;
  logic [7:0] byte_q, byte_d, char_q, char_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, code_q, code_d;
  logic err_q, err_d, valid_q, valid_d;
  logic dec_valid;
  logic [1:0] dec_code;
  uart_cmd_decode u_dec (.ch(char_q), .valid(dec_valid), .code(dec_code));
  // next state, line bookkeeping and FIFO handshakes
  always_comb begin
    state_d = state_q;
    byte_d = byte_q;
    char_d = char_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    err_d = err_q;
    valid_d = 1'b0;
    code_d = code_q;
    fifo.rx_pop = 1'b0;
    fifo.tx_push = 1'b0;
    fifo.tx_push_data = 8'h00;
    case (state_q)
      S_IDLE: begin
        fifo.rx_pop = !fifo.rx_empty;
        if (!fifo.rx_empty) begin
          byte_d = fifo.rx_data;
`ifdef UART_CMD_ECHO_EN
          state_d = S_ECHO;
`else
          state_d = S_EVAL;
`endif
        end
      end
`ifdef UART_CMD_ECHO_EN
      S_ECHO: begin
        fifo.tx_push = !fifo.tx_full;
        fifo.tx_push_data = byte_q;
        state_d = fifo.tx_full ? S_ECHO : S_EVAL;
      end
`endif
      S_EVAL: begin
        state_d = S_IDLE;
        if (byte_q == ASCII_CR) begin
          if (cnt_q != '0) begin
            valid_d = cnt_q == CNT_W'(1) && dec_valid;
            err_d = !valid_d;
            code_d = valid_d ? dec_code : code_q;
            state_d = S_RESP;
          end
        end else if (byte_q != ASCII_LF) begin
          char_d = cnt_q == '0 ? byte_q : char_q;
          cnt_d = cnt_q == LMAX ? cnt_q : cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        fifo.tx_push = !fifo.tx_full;
        fifo.tx_push_data = resp_byte(err_q, idx_q);
        if (!fifo.tx_full) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cnt_d = '0;
            char_d = 8'h00;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      byte_q <= 8'h00;
      char_q <= 8'h00;
      cnt_q <= '0;
      idx_q <= 2'd0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      code_q <= 2'd0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      char_q <= char_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      err_q <= err_d;
      valid_q <= valid_d;
      code_q <= code_d;
    end
  end
  assign o_cmd_valid = valid_q;
  assign o_cmd_code = code_q;
  assign o_busy = state_q != S_IDLE;
endmodule
